uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmitter that serialises one word per valid/ready handshake into an asynchronous frame: start bit, LSB-first data, optional parity, one or two stop bits. It generalises the fixed 8N1 transmitter with a configurable bit period, data width, parity mode and stop-bit count. Unlike the fixed block, it also captures data at acceptance and provides a back-pressure handshake. It sits between a byte/word producer (register file, FIFO, switch bank) and the board TX pin.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 1..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- i_clk  in  1  sole clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  producer has a word on i_data.
- i_data  in  DATA_BITS  word to send; sampled only at acceptance.
- o_ready  out  1  transmitter can accept a word (high only in IDLE).
- o_txd  out  1  serial line; idles high; registered.
- o_busy  out  1  frame in progress (= not o_ready).
- o_done  out  1  one-cycle pulse when a frame's last stop bit completes.

## Operation
- Acceptance: rising edge with i_valid=1 and o_ready=1. At that edge:
  - i_data is loaded into an internal shift register.
  - Parity is computed from the captured word.
  - The baud counter clears.
  - State goes to START.
- Later changes on i_data do not affect the frame in flight.
- States: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0. A bit ends on the cycle the count equals CLKS_PER_BIT-1.
  - Width = clog2(CLKS_PER_BIT), minimum 1.
  - With CLKS_PER_BIT=1, every cycle ends a bit.
- DATA: sends the shift-register LSB, shifting right at each bit end. A bit index counts 0..DATA_BITS-1; the last index exits to PARITY or STOP.
- PARITY bit value:
  - Odd: XNOR-reduce of the data.
  - Even: XOR-reduce of the data.
  - In both cases the ones count over data+parity has the selected parity.
- STOP: line high for STOP_BITS bit periods, then IDLE with o_done=1 for one cycle.
- o_txd by state: IDLE=1, START=0, DATA=current LSB, PARITY=parity bit, STOP=1. It is driven from a flop, so it changes one cycle after the state/count decision. The flop lag is uniform, so every bit still lasts exactly CLKS_PER_BIT cycles.
- An undefined state encoding recovers to IDLE on the next edge.
- i_valid while busy is ignored. There is no queueing; the producer holds i_valid until it sees o_ready.

## Timing
- Reset value of every output and state:
  - o_txd=1, o_ready=1, o_busy=0, o_done=0.
  - state=IDLE; counters and shift register zero.
- Reset is asynchronous and acts immediately, including mid-frame; the line returns high with no stop-bit completion.
- Acceptance at edge E: o_txd falls after edge E+1 (one-cycle output register latency).
  - o_txd is then low for exactly CLKS_PER_BIT cycles.
  - Each following bit also lasts exactly CLKS_PER_BIT cycles.
- Frame length on the line: F = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × CLKS_PER_BIT cycles.
- o_ready is low from edge E through the end of the final stop-bit count. It returns high in the same cycle that o_done pulses, which is F cycles after edge E.
- Back-to-back with i_valid held high: the next acceptance occurs on the edge ending the o_done cycle. The guaranteed inter-frame idle-high gap on o_txd is 1 cycle (from output latency); no other gap is inserted.
- o_done and acceptance of the next word never conflict; o_done is combinational-free and registered.

## Test plan
- 8N1, CLKS_PER_BIT=16, send 0x55:
  - o_txd sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each exactly 16 cycles.
  - o_ready low for 160 cycles.
  - o_done pulses once.
- 8E1, send 0xA5 (four ones): parity bit 0, frame 176 cycles. 8O1, send 0xA5: parity bit 1.
- 7N2, CLKS_PER_BIT=4, send 0x7F:
  - 7 data ones, then stop high for 8 cycles.
  - o_done 40 cycles after acceptance.
  - i_data changed to 0x00 mid-frame does not alter the line.
- Back-to-back: i_valid held high with 0x01 then 0x80, 8N1, CLKS_PER_BIT=16.
  - Two frames separated by exactly 1 idle-high cycle.
  - Two o_done pulses 161 cycles apart.
  - i_valid pulses while busy are ignored.
- Reset mid-frame: assert i_reset during data bit 3.
  - o_txd=1, o_ready=1, o_busy=0 with no clock edge; no o_done.
  - After release, the next accepted word transmits correctly.
- Edge case CLKS_PER_BIT=1, 9-bit even parity, send 0x1FF: one cycle per bit, parity bit 1, frame 12 cycles.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// One word is accepted per valid/ready handshake and captured at acceptance.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_txd,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2:0]           o_state
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [3:0]           bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bit, par_bit_n;
    logic                 txd_n;
    logic                 done_n;
    logic                 bit_end;

    // Handshake: a word transfers on a rising edge where i_valid and o_ready are both high;
    // o_ready is high only in IDLE and i_valid is ignored at all other times.
    assign o_ready = (state == S_IDLE);
    assign o_busy  = ~o_ready;
    assign o_state = state;
    assign bit_end = (cnt == CNT_MAX);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            o_txd    <= 1'b1;
            o_done   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            stop_idx <= stop_idx_n;
            shreg    <= shreg_n;
            par_bit  <= par_bit_n;
            o_txd    <= txd_n;
            o_done   <= done_n;
        end
    end

    // o_txd is registered from the current state, so every bit is delayed by the same single cycle.
    always_comb begin
        state_n    = state;
        cnt_n      = bit_end ? '0 : cnt + CNT_W'(1);
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        shreg_n    = shreg;
        par_bit_n  = par_bit;
        txd_n      = 1'b1;
        done_n     = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (i_valid) begin
                    shreg_n    = i_data;
                    par_bit_n  = (PARITY == 1) ? ~^i_data : ^i_data;
                    bit_idx_n  = '0;
                    stop_idx_n = 1'b0;
                    state_n    = S_START;
                end
            end
            S_START: begin
                txd_n = 1'b0;
                if (bit_end) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                txd_n = shreg[0];
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bit_idx == BIT_LAST) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                txd_n = par_bit;
                if (bit_end) begin
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                txd_n = 1'b1;
                if (bit_end) begin
                    if (stop_idx == STOP_LAST) begin
                        stop_idx_n = 1'b0;
                        done_n     = 1'b1;
                        state_n    = S_IDLE;
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
